// File: rtl/wasm_lsu.sv
// wasm_lsu: WASM load/store unit, initiator on the memory data bus.
// One op in flight; load data is sign/zero-extended locally.
package wasm_lsu_pkg;

  typedef enum logic [4:0] {
    MEM_NONE,
    MEM_LOAD_I32, MEM_LOAD_I64,
    MEM_LOAD_F32, MEM_LOAD_F64,
    MEM_LOAD_I8_S, MEM_LOAD_I8_U,
    MEM_LOAD_I16_S, MEM_LOAD_I16_U,
    MEM_LOAD_I32_S, MEM_LOAD_I32_U,
    MEM_STORE_I32, MEM_STORE_I64,
    MEM_STORE_F32, MEM_STORE_F64,
    MEM_STORE_I8, MEM_STORE_I16,
    MEM_STORE_I32_64
  } mem_op_t;

  typedef enum logic [1:0] {
    TRAP_NONE,
    TRAP_OUT_OF_BOUNDS
  } trap_t;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [3:0]  size;
    logic [63:0] wdata;
  } mem_bus_req_t;

  typedef struct packed {
    logic        ready;
    logic        rvalid;
    logic [63:0] rdata;
    logic        error;
  } mem_bus_resp_t;

endpackage

module wasm_lsu
  import wasm_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          op_valid_i,
  output logic          op_ready_o,
  input  mem_op_t       op_i,
  input  logic [31:0]   base_i,
  input  logic [31:0]   offset_i,
  input  logic [63:0]   wdata_i,
  output mem_bus_req_t  mem_req_o,
  input  mem_bus_resp_t mem_resp_i,
  output mem_op_t       mem_op_o,
  output logic          result_valid_o,
  output logic [63:0]   result_o,
  output trap_t         trap_o,
  output logic          timeout_o,
  output logic          busy_o
);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, DONE
  } state_t;

  state_t      state;
  logic [32:0] ea;
  logic [3:0]  size;
  logic [63:0] wmask;
  logic        is_store;
  logic [31:0] cnt;
  logic        tmo;
  logic [63:0] rd;
  logic [63:0] ext;

  assign ea         = {1'b0, base_i} + {1'b0, offset_i};
  assign op_ready_o = (state == IDLE);
  assign busy_o     = (state != IDLE);
  assign rd         = mem_resp_i.rdata;
  assign tmo        = (TIMEOUT_CYCLES != 0) &&
                      (cnt == TIMEOUT_CYCLES - 1);

  assign is_store = op_i inside {
    MEM_STORE_I32, MEM_STORE_I64,
    MEM_STORE_F32, MEM_STORE_F64,
    MEM_STORE_I8, MEM_STORE_I16,
    MEM_STORE_I32_64
  };

  always_comb begin
    size = 4'd4;
    unique case (1'b1)
      (op_i inside {MEM_LOAD_I8_S, MEM_LOAD_I8_U,
                    MEM_STORE_I8}):
        size = 4'd1;
      (op_i inside {MEM_LOAD_I16_S, MEM_LOAD_I16_U,
                    MEM_STORE_I16}):
        size = 4'd2;
      (op_i inside {MEM_LOAD_I64, MEM_LOAD_F64,
                    MEM_STORE_I64, MEM_STORE_F64}):
        size = 4'd8;
      default:
        size = 4'd4;
    endcase
  end

  always_comb begin
    wmask = '1;
    unique case (1'b1)
      (size == 4'd1): wmask = 64'h0000_0000_0000_00ff;
      (size == 4'd2): wmask = 64'h0000_0000_0000_ffff;
      (size == 4'd4): wmask = 64'h0000_0000_ffff_ffff;
      default:        wmask = '1;
    endcase
  end

  // extension keyed on the latched op, never on responder behaviour
  always_comb begin
    ext = rd;
    unique case (1'b1)
      (mem_op_o == MEM_LOAD_I8_S):
        ext = {{56{rd[7]}}, rd[7:0]};
      (mem_op_o == MEM_LOAD_I8_U):
        ext = {56'd0, rd[7:0]};
      (mem_op_o == MEM_LOAD_I16_S):
        ext = {{48{rd[15]}}, rd[15:0]};
      (mem_op_o == MEM_LOAD_I16_U):
        ext = {48'd0, rd[15:0]};
      (mem_op_o == MEM_LOAD_I32_S):
        ext = {{32{rd[31]}}, rd[31:0]};
      (mem_op_o inside {MEM_LOAD_I32, MEM_LOAD_F32,
                        MEM_LOAD_I32_U}):
        ext = {32'd0, rd[31:0]};
      default:
        ext = rd;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      mem_req_o      <= '0;
      mem_op_o       <= MEM_NONE;
      result_valid_o <= 1'b0;
      result_o       <= '0;
      trap_o         <= TRAP_NONE;
      timeout_o      <= 1'b0;
      cnt            <= '0;
    end else begin
      result_valid_o <= 1'b0;
      result_o       <= '0;
      trap_o         <= TRAP_NONE;
      timeout_o      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (op_valid_i) begin
            cnt <= '0;
            if (ea[32]) begin
              state          <= DONE;
              result_valid_o <= 1'b1;
              trap_o         <= TRAP_OUT_OF_BOUNDS;
            end else begin
              state     <= ISSUE;
              mem_op_o  <= op_i;
              mem_req_o <= '{valid: 1'b1,
                             write: is_store,
                             addr:  ea[31:0],
                             size:  size,
                             wdata: wdata_i & wmask};
            end
          end
        end
        ISSUE: begin
          if (mem_resp_i.ready) begin
            mem_req_o.valid <= 1'b0;
            if (mem_resp_i.error) begin
              state          <= DONE;
              result_valid_o <= 1'b1;
              trap_o         <= TRAP_OUT_OF_BOUNDS;
            end else if (mem_req_o.write) begin
              state          <= DONE;
              result_valid_o <= 1'b1;
            end else if (mem_resp_i.rvalid) begin
              state          <= DONE;
              result_valid_o <= 1'b1;
              result_o       <= ext;
            end else begin
              state <= WAIT;
              cnt   <= cnt + 32'd1;
            end
          end else if (tmo) begin
            state           <= DONE;
            mem_req_o.valid <= 1'b0;
            result_valid_o  <= 1'b1;
            trap_o          <= TRAP_OUT_OF_BOUNDS;
            timeout_o       <= 1'b1;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        WAIT: begin
          if (mem_resp_i.error) begin
            state          <= DONE;
            result_valid_o <= 1'b1;
            trap_o         <= TRAP_OUT_OF_BOUNDS;
          end else if (mem_resp_i.rvalid) begin
            state          <= DONE;
            result_valid_o <= 1'b1;
            result_o       <= ext;
          end else if (tmo) begin
            state          <= DONE;
            result_valid_o <= 1'b1;
            trap_o         <= TRAP_OUT_OF_BOUNDS;
            timeout_o      <= 1'b1;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wasm_lsu.sv
// tb_wasm_lsu: randomized scoreboard bench for wasm_lsu.
// Driver queues expectations; responder and monitor check independently.
module tb_wasm_lsu;
  import wasm_lsu_pkg::*;

  localparam int TMO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          op_valid_i;
  logic          op_ready_o;
  mem_op_t       op_i;
  logic [31:0]   base_i;
  logic [31:0]   offset_i;
  logic [63:0]   wdata_i;
  mem_bus_req_t  mem_req_o;
  mem_bus_resp_t mem_resp_i;
  mem_op_t       mem_op_o;
  logic          result_valid_o;
  logic [63:0]   result_o;
  trap_t         trap_o;
  logic          timeout_o;
  logic          busy_o;

  wasm_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk),
    .rst(rst),
    .op_valid_i(op_valid_i),
    .op_ready_o(op_ready_o),
    .op_i(op_i),
    .base_i(base_i),
    .offset_i(offset_i),
    .wdata_i(wdata_i),
    .mem_req_o(mem_req_o),
    .mem_resp_i(mem_resp_i),
    .mem_op_o(mem_op_o),
    .result_valid_o(result_valid_o),
    .result_o(result_o),
    .trap_o(trap_o),
    .timeout_o(timeout_o),
    .busy_o(busy_o)
  );

  typedef struct {
    mem_op_t     op;
    logic [31:0] base;
    logic [31:0] off;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          d_rdy;
    int          d_rv;
    bit          err;
    bit          hang;
  } txn_t;

  typedef struct {
    logic [63:0] res;
    trap_t       trap;
    bit          tmo;
    int          lat;
    int          t0;
  } exp_t;

  txn_t planq[$];
  exp_t expq[$];
  int nvec = 0;
  int nerr = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [63:0] act,
                              logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endfunction

  function automatic bit is_st(mem_op_t op);
    return op inside {MEM_STORE_I32, MEM_STORE_I64,
                      MEM_STORE_F32, MEM_STORE_F64,
                      MEM_STORE_I8, MEM_STORE_I16,
                      MEM_STORE_I32_64};
  endfunction

  function automatic int nbytes(mem_op_t op);
    case (op)
      MEM_LOAD_I8_S, MEM_LOAD_I8_U, MEM_STORE_I8: return 1;
      MEM_LOAD_I16_S, MEM_LOAD_I16_U, MEM_STORE_I16: return 2;
      MEM_LOAD_I64, MEM_LOAD_F64,
      MEM_STORE_I64, MEM_STORE_F64: return 8;
      default: return 4;
    endcase
  endfunction

  function automatic logic [63:0] keep(logic [63:0] d, int n);
    logic [63:0] r = '0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [63:0] ref_load(mem_op_t op,
                                           logic [63:0] d);
    case (op)
      MEM_LOAD_I8_S:  return 64'($signed(d[7:0]));
      MEM_LOAD_I8_U:  return 64'(d[7:0]);
      MEM_LOAD_I16_S: return 64'($signed(d[15:0]));
      MEM_LOAD_I16_U: return 64'(d[15:0]);
      MEM_LOAD_I32_S: return 64'($signed(d[31:0]));
      MEM_LOAD_I32, MEM_LOAD_F32, MEM_LOAD_I32_U:
        return 64'(d[31:0]);
      default: return d;
    endcase
  endfunction

  function automatic txn_t mk(mem_op_t op, logic [31:0] b,
                              logic [31:0] o, logic [63:0] w,
                              logic [63:0] r, int dr, int dv,
                              bit er, bit hg);
    txn_t t;
    t.op = op; t.base = b; t.off = o; t.wdata = w;
    t.rdata = r; t.d_rdy = dr; t.d_rv = dv;
    t.err = er; t.hang = hg;
    return t;
  endfunction

  task automatic issue(input txn_t t);
    exp_t e;
    logic [32:0] ea;
    int n;
    n = 0;
    while (!op_ready_o) begin
      // junk requests while busy must be ignored
      op_valid_i = 1'($urandom_range(0, 1));
      op_i = mem_op_t'($urandom_range(1, 17));
      base_i = $urandom;
      offset_i = $urandom;
      wdata_i = {$urandom, $urandom};
      @(negedge clk);
      n++;
      if (n > 100) begin
        op_valid_i = 1'b0;
        chk("ready_wait", 64'(op_ready_o), 64'd1);
        return;
      end
    end
    ea = {1'b0, t.base} + {1'b0, t.off};
    e.t0 = cyc;
    e.tmo = 1'b0;
    e.res = '0;
    e.trap = TRAP_NONE;
    if (ea[32]) begin
      e.trap = TRAP_OUT_OF_BOUNDS;
      e.lat = 1;
    end else begin
      planq.push_back(t);
      if (t.hang) begin
        e.trap = TRAP_OUT_OF_BOUNDS;
        e.tmo = 1'b1;
        e.lat = 1 + TMO;
      end else begin
        e.lat = 2 + t.d_rdy + (is_st(t.op) ? 0 : t.d_rv);
        if (t.err) e.trap = TRAP_OUT_OF_BOUNDS;
        else if (!is_st(t.op)) e.res = ref_load(t.op, t.rdata);
      end
    end
    expq.push_back(e);
    op_valid_i = 1'b1;
    op_i = t.op;
    base_i = t.base;
    offset_i = t.off;
    wdata_i = t.wdata;
    @(negedge clk);
    op_valid_i = 1'b0;
  endtask

  // responder: one plan per bus request
  txn_t rp;
  int ph = 0;
  int rc = 0;
  always @(negedge clk) begin
    mem_resp_i = '0;
    mem_resp_i.rdata = {$urandom, $urandom};
    if (rst) begin
      ph = 0;
    end else begin
      if (ph == 0 && mem_req_o.valid) begin
        if (planq.size() == 0)
          chk("spurious_req", 64'(mem_req_o.valid), 64'd0);
        else begin
          rp = planq.pop_front();
          ph = 1;
          rc = 0;
        end
      end
      if (ph == 1) begin
        if (!mem_req_o.valid) begin
          if (!rp.hang)
            chk("req_drop", 64'(mem_req_o.valid), 64'd1);
          ph = 0;
        end else begin
          chk("req_addr", 64'(mem_req_o.addr),
              64'(rp.base + rp.off));
          chk("req_size", 64'(mem_req_o.size),
              64'(nbytes(rp.op)));
          chk("req_write", 64'(mem_req_o.write),
              64'(is_st(rp.op)));
          chk("req_wdata", mem_req_o.wdata,
              keep(rp.wdata, nbytes(rp.op)));
          chk("req_op", 64'(mem_op_o), 64'(rp.op));
          if (!rp.hang && rc == rp.d_rdy) begin
            mem_resp_i.ready = 1'b1;
            if (is_st(rp.op)) begin
              mem_resp_i.error = rp.err;
              ph = 0;
            end else if (rp.d_rv == 0) begin
              mem_resp_i.rvalid = 1'b1;
              mem_resp_i.rdata = rp.rdata;
              mem_resp_i.error = rp.err;
              ph = 0;
            end else begin
              ph = 2;
              rc = 0;
            end
          end else begin
            rc++;
          end
        end
      end else if (ph == 2) begin
        chk("wait_valid", 64'(mem_req_o.valid), 64'd0);
        rc++;
        if (rc == rp.d_rv) begin
          mem_resp_i.rvalid = 1'b1;
          mem_resp_i.rdata = rp.rdata;
          mem_resp_i.error = rp.err;
          ph = 0;
        end
      end
    end
  end

  // monitor: pops one expectation per completion pulse
  exp_t me;
  always @(negedge clk) begin
    if (!rst) begin
      if (result_valid_o) begin
        if (expq.size() == 0)
          chk("extra_result", 64'(result_valid_o), 64'd0);
        else begin
          me = expq.pop_front();
          chk("result", result_o, me.res);
          chk("trap", 64'(trap_o), 64'(me.trap));
          chk("timeout", 64'(timeout_o), 64'(me.tmo));
          chk("latency", 64'(cyc - me.t0), 64'(me.lat));
        end
      end else begin
        chk("quiet_result", result_o, 64'd0);
        chk("quiet_flags", 64'({trap_o, timeout_o}), 64'd0);
      end
      chk("busy", 64'(busy_o), 64'(!op_ready_o));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  txn_t t;
  int n;
  initial begin
    rst = 1'b1;
    op_valid_i = 1'b0;
    op_i = MEM_NONE;
    base_i = '0;
    offset_i = '0;
    wdata_i = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 64'(op_ready_o), 64'd1);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_req", 64'(mem_req_o == '0), 64'd1);
    chk("rst_rvalid", 64'(result_valid_o), 64'd0);
    chk("rst_result", result_o, 64'd0);
    chk("rst_trap", 64'(trap_o), 64'(TRAP_NONE));
    chk("rst_tmo", 64'(timeout_o), 64'd0);

    issue(mk(MEM_LOAD_I32, 32'h10, 32'h4, '0,
             64'hffff_ffff_dead_beef, 0, 0, 0, 0));
    issue(mk(MEM_LOAD_I8_S, 32'h0, 32'h0, '0,
             64'h1234_5678_9abc_de80, 0, 0, 0, 0));
    issue(mk(MEM_LOAD_I16_U, 32'h40, 32'h2, '0,
             64'hffff_ffff_ffff_8001, 0, 1, 0, 0));
    issue(mk(MEM_STORE_I16, 32'h80, 32'h0,
             64'h1234_5678, '0, 3, 0, 0, 0));
    issue(mk(MEM_LOAD_I64, 32'hffff_fff0, 32'h20, '0,
             '1, 0, 0, 0, 0));
    issue(mk(MEM_LOAD_I32, 32'h100, 32'h0, '0,
             64'h55, 1, 0, 1, 0));
    issue(mk(MEM_LOAD_I16_S, 32'h100, 32'h0, '0,
             64'h8000, 0, 2, 1, 0));
    issue(mk(MEM_LOAD_I32, 32'h200, 32'h0, '0,
             '0, 0, 0, 0, 1));

    for (int i = 0; i < 300; i++) begin
      t.op = mem_op_t'($urandom_range(1, 17));
      if ($urandom_range(0, 3) == 0) begin
        t.base = $urandom;
        t.off = $urandom;
      end else begin
        t.base = $urandom_range(0, 32'hffff);
        t.off = $urandom_range(0, 32'hfff);
      end
      t.wdata = {$urandom, $urandom};
      t.rdata = {$urandom, $urandom};
      t.d_rdy = $urandom_range(0, 3);
      t.d_rv = $urandom_range(0, 2);
      t.err = ($urandom_range(0, 7) == 0);
      t.hang = ($urandom_range(0, 15) == 0);
      issue(t);
    end

    // reset while the LSU sits in WAIT drops the op silently
    issue(mk(MEM_LOAD_I64, 32'h300, 32'h8, '0,
             64'h1, 0, 3, 0, 0));
    @(posedge clk);
    #1 rst = 1'b1;
    void'(expq.pop_back());
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready", 64'(op_ready_o), 64'd1);
    chk("rst_mid_req", 64'(mem_req_o == '0), 64'd1);
    issue(mk(MEM_LOAD_I32, 32'h10, 32'h4, '0,
             64'h0123_4567_89ab_cdef, 0, 0, 0, 0));

    n = 0;
    while ((expq.size() != 0 || planq.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(expq.size() + planq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/wasm_lsu.md
Name: wasm_lsu

Overview:
- Load/store unit: the initiator side of the mem_bus_req_t / mem_bus_resp_t data bus that wasm_memory and the AXI-lite adapter serve as responders.
- Accepts one WASM load/store op at a time from the execute stage and computes the 33-bit effective address.
- Issues a single bus request, waits for the response, then normalises and sign/zero-extends load data.
- Returns a 64-bit result or a trap to the execute stage. Its load result does not depend on the responder performing extension.

Parameters:
TIMEOUT_CYCLES, 256, max cycles in ISSUE+WAIT before a timeout trap; 0 disables the timeout.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
op_valid_i  in  1  op request from execute stage
op_ready_o  out  1  LSU can accept an op; high only in IDLE
op_i  in  mem_op_t  operation, MEM_LOAD_* or MEM_STORE_{I32,I64,F32,F64,I8,I16,I32_64}
base_i  in  32  address operand popped from the value stack
offset_i  in  32  memarg offset immediate
wdata_i  in  64  store value
mem_req_o  out  mem_bus_req_t  bus request: valid, write, addr, size, wdata
mem_resp_i  in  mem_bus_resp_t  bus response: ready, rvalid, rdata, error
mem_op_o  out  mem_op_t  latched op, forwarded to the responder
result_valid_o  out  1  one-cycle completion pulse
result_o  out  64  extended load data; 0 for stores and traps
trap_o  out  trap_t  valid with result_valid_o
timeout_o  out  1  with result_valid_o: completion was caused by the timeout
busy_o  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset values: state=IDLE, op_ready_o=1, mem_req_o all-zero, result_valid_o=0, result_o=0, trap_o=TRAP_NONE, timeout_o=0, busy_o=0, timeout counter=0.
- Effective address: ea = {1'b0,base_i} + {1'b0,offset_i}, 33 bits. Computed and latched at accept (op_valid_i && op_ready_o).
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE, on accept:
  - If ea[32]=1: go to DONE with trap=TRAP_OUT_OF_BOUNDS. No bus request is issued.
  - Otherwise: latch op, ea[31:0], size and masked wdata, then go to ISSUE.
- Size mapping:
  - 1 byte: I8_* loads, STORE_I8.
  - 2 bytes: I16_* loads, STORE_I16.
  - 4 bytes: I32, F32, I32_S, I32_U loads; STORE_I32, STORE_F32, STORE_I32_64.
  - 8 bytes: I64, F64 loads; STORE_I64, STORE_F64.
- wdata masking: bytes at or above the access size are driven 0.
- ISSUE: mem_req_o.valid=1, with all request fields held stable until mem_resp_i.ready=1 is sampled. On that cycle:
  - error=1 -> DONE, TRAP_OUT_OF_BOUNDS.
  - write -> DONE, TRAP_NONE.
  - read with rvalid=1 -> capture rdata, DONE.
  - read with rvalid=0 -> WAIT; valid drops next cycle.
- WAIT: mem_req_o.valid=0.
  - rvalid=1 -> capture rdata, DONE.
  - error=1 -> DONE, TRAP_OUT_OF_BOUNDS.
  - If rvalid and error are both high, error wins.
- Timeout:
  - Counter clears on accept and increments each cycle in ISSUE or WAIT.
  - When it reaches TIMEOUT_CYCLES (parameter nonzero): go to DONE with TRAP_OUT_OF_BOUNDS and timeout_o=1. mem_req_o.valid deasserts.
  - Any response arriving later in IDLE is ignored.
- DONE: for one cycle, result_valid_o=1 with result_o, trap_o and timeout_o. Next state is IDLE. These outputs are 0/TRAP_NONE at all other times.
- Load extension, applied to captured rdata per op, regardless of upper rdata bits:
  - I8_S: sext bits [7:0]. I8_U: zext [7:0].
  - I16_S/U: sext/zext [15:0].
  - I32, F32, I32_U: zext [31:0]. I32_S: sext [31:0].
  - I64, F64: all 64 bits.
- Latency with a responder that completes in the cycle it is accepted: accept at cycle T, mem_req_o.valid at T+1, result_valid_o at T+2. An address-overflow trap gives result_valid_o at T+1.
- A new accept is possible in the cycle after DONE. Throughput is 1 op per 3 cycles at best.
- mem_op_o holds the latched op while in ISSUE/WAIT; otherwise it holds the last value.
- Reset asserted mid-operation: the next edge forces IDLE with the reset values. The in-flight op is dropped, no result_valid_o is produced, and mem_req_o.valid is 0 from that edge.
- op_valid_i outside IDLE is ignored and does not queue.

Test Plan:
- i32.load, base=0x10, offset=4, responder returns rdata=0xFFFFFFFF_DEADBEEF -> request addr 0x14, size 4, write=0; result_o=0x00000000_DEADBEEF at T+2.
- i64.load8_s, base=0, offset=0, rdata=0x...80 -> result_o=0xFFFFFFFF_FFFFFF80. i32.load16_u with rdata low half 0x8001 -> result_o=0x8001.
- i32.store16, wdata_i=0x1234_5678, ready held low 3 cycles -> addr, size and wdata=0x5678 stay stable throughout; exactly one completion; trap_o=TRAP_NONE.
- base=0xFFFFFFF0, offset=0x20 -> no mem_req_o.valid; result_valid_o at T+1 with TRAP_OUT_OF_BOUNDS. Responder error=1 on a valid address -> TRAP_OUT_OF_BOUNDS.
- TIMEOUT_CYCLES=4, responder never ready -> result_valid_o with timeout_o=1 after 4 cycles in ISSUE; op_ready_o=1 the next cycle.
- rst pulsed while in WAIT -> next cycle IDLE, mem_req_o.valid=0, no result_valid_o; a following i32.load completes normally.
